regfile_sb: RTL and testbench

- Parametrised integer register file for the decode stage: two combinational read ports, one write-back port and a per-register scoreboard of busy bits.
- Decode uses it to detect RAW hazards against in-flight instructions and to raise a stall.
- Optional write-through bypass forwards same-cycle write-back data to the read ports.
- Generalises the fixed 32x32, no-hazard-tracking register file it replaces.

---
 rtl/regfile_sb.sv | 107 ++++++++++
 tb/tb_regfile_sb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write-back port
// and a per-register busy scoreboard used by decode to stall on RAW hazards.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall,
  input  logic            rs1_use,
  input  logic            rs2_use,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);

  logic [XLEN-1:0] regs_reg [NREG];
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [AW:0]     busy_cnt_reg;
  logic [AW:0]     busy_cnt_next;

  // Priority per register: flush, then a newer issue, then the write-back clear.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      localparam bit HARD_ZERO = HAS_ZERO && (gi == 0);
      logic set_bit;
      logic clr_bit;
      assign set_bit = iss_en && (iss_rd == AW'(gi)) && !HARD_ZERO;
      assign clr_bit = wb_en && (wb_rd == AW'(gi));
      assign busy_next[gi] = flush   ? 1'b0 :
                             set_bit ? 1'b1 :
                             clr_bit ? 1'b0 : busy_reg[gi];
    end
  endgenerate

  always_comb begin
    busy_cnt_next = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt_next = busy_cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      if (wb_en && !(HAS_ZERO && (wb_rd == '0))) begin
        regs_reg[wb_rd] <= wb_data;
      end
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  // A same-cycle write-back both forwards its data and hides the busy bit it clears.
  always_comb begin
    rd1      = regs_reg[rs1];
    rs1_busy = busy_reg[rs1];
    if (HAS_BYP && wb_en && (wb_rd == rs1)) begin
      rd1      = wb_data;
      rs1_busy = 1'b0;
    end
    if (HAS_ZERO && (rs1 == '0)) begin
      rd1      = '0;
      rs1_busy = 1'b0;
    end
  end

  always_comb begin
    rd2      = regs_reg[rs2];
    rs2_busy = busy_reg[rs2];
    if (HAS_BYP && wb_en && (wb_rd == rs2)) begin
      rd2      = wb_data;
      rs2_busy = 1'b0;
    end
    if (HAS_ZERO && (rs2 == '0)) begin
      rd2      = '0;
      rs2_busy = 1'b0;
    end
  end

  assign stall    = (rs1_use && rs1_busy) || (rs2_use && rs2_busy);
  assign busy_cnt = busy_cnt_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing instance and one non-bypassing
// instance share all inputs so forwarding differences can be observed side by side.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   rs1, rs2, iss_rd, wb_rd;
  logic            rs1_use, rs2_use, iss_en, wb_en, flush;
  logic [XLEN-1:0] wb_data;

  logic [XLEN-1:0] rd1, rd2;
  logic            rs1_busy, rs2_busy, stall;
  logic [AW:0]     busy_cnt;

  logic [XLEN-1:0] rd1_nb, rd2_nb;
  logic            rs1_busy_nb, rs2_busy_nb, stall_nb;
  logic [AW:0]     busy_cnt_nb;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall),
    .rs1_use(rs1_use), .rs2_use(rs2_use), .iss_en(iss_en), .iss_rd(iss_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd1(rd1_nb), .rd2(rd2_nb),
    .rs1_busy(rs1_busy_nb), .rs2_busy(rs2_busy_nb), .stall(stall_nb),
    .rs1_use(rs1_use), .rs2_use(rs2_use), .iss_en(iss_en), .iss_rd(iss_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .busy_cnt(busy_cnt_nb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    iss_en = 1'b0; wb_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    iss_en = 1'b1; iss_rd = 5'd6; rs1 = 5'd5;
    #1;
    tests_run++;
    if (rd1 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL reset_pre_bypass: got %h want %h", rd1, 32'hDEADBEEF); end
    tick;
    idle;
    #1;
    tests_run++;
    if (rd1 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL reset_pre_rd1: got %h want %h", rd1, 32'hDEADBEEF); end
    tests_run++;
    if (busy_cnt !== 6'd1) begin tests_failed++; $display("FAIL reset_pre_cnt: got %0d want 1", busy_cnt); end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (rd1 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd1: got %h want 0", rd1); end
    tests_run++;
    if (busy_cnt !== 6'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt); end
    rs1 = 5'd6;
    #1;
    tests_run++;
    if (rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy6: got %b want 0", rs1_busy); end
    reset = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_zero_reg;
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; rs1 = 5'd0;
    #1;
    tests_run++;
    if (rd1 !== 32'h0) begin tests_failed++; $display("FAIL zero_bypass_rd1: got %h want 0", rd1); end
    tick;
    idle;
    iss_en = 1'b1; iss_rd = 5'd0;
    tick;
    idle;
    #1;
    tests_run++;
    if (rd1 !== 32'h0) begin tests_failed++; $display("FAIL zero_rd1: got %h want 0", rd1); end
    tests_run++;
    if (rd1_nb !== 32'h0) begin tests_failed++; $display("FAIL zero_rd1_nb: got %h want 0", rd1_nb); end
    tests_run++;
    if (rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy: got %b want 0", rs1_busy); end
    tests_run++;
    if (busy_cnt !== 6'd0) begin tests_failed++; $display("FAIL zero_cnt: got %0d want 0", busy_cnt); end
    $display("[TB] test_zero_reg done");
  endtask

  task automatic test_hazard;
    iss_en = 1'b1; iss_rd = 5'd7; rs1 = 5'd7; rs1_use = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL hazard_issue_cycle_stall: got %b want 0", stall); end
    tick;
    idle;
    #1;
    tests_run++;
    if (rs1_busy !== 1'b1) begin tests_failed++; $display("FAIL hazard_busy: got %b want 1", rs1_busy); end
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL hazard_stall: got %b want 1", stall); end
    tests_run++;
    if (busy_cnt !== 6'd1) begin tests_failed++; $display("FAIL hazard_cnt: got %0d want 1", busy_cnt); end
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5A5A5;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL hazard_wb_stall: got %b want 0", stall); end
    tests_run++;
    if (rd1 !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL hazard_wb_rd1: got %h want a5a5a5a5", rd1); end
    tests_run++;
    if (stall_nb !== 1'b1) begin tests_failed++; $display("FAIL hazard_wb_stall_nb: got %b want 1", stall_nb); end
    tick;
    idle;
    rs1_use = 1'b0;
    #1;
    tests_run++;
    if (busy_cnt !== 6'd0) begin tests_failed++; $display("FAIL hazard_after_cnt: got %0d want 0", busy_cnt); end
    tests_run++;
    if (rd1 !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL hazard_after_rd1: got %h want a5a5a5a5", rd1); end
    $display("[TB] test_hazard done");
  endtask

  task automatic test_iss_wb_same_reg;
    iss_en = 1'b1; iss_rd = 5'd9;
    tick;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0099;
    tick;
    idle;
    rs2 = 5'd9;
    #1;
    tests_run++;
    if (rd2 !== 32'h99) begin tests_failed++; $display("FAIL same_rd2: got %h want 99", rd2); end
    tests_run++;
    if (rs2_busy !== 1'b1) begin tests_failed++; $display("FAIL same_busy: got %b want 1", rs2_busy); end
    tests_run++;
    if (busy_cnt !== 6'd1) begin tests_failed++; $display("FAIL same_cnt: got %0d want 1", busy_cnt); end
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0099;
    tick;
    idle;
    #1;
    tests_run++;
    if (busy_cnt !== 6'd0) begin tests_failed++; $display("FAIL same_clear_cnt: got %0d want 0", busy_cnt); end
    $display("[TB] test_iss_wb_same_reg done");
  endtask

  task automatic test_flush;
    iss_en = 1'b1; iss_rd = 5'd3; tick;
    iss_rd = 5'd4; tick;
    iss_rd = 5'd12; tick;
    idle;
    #1;
    tests_run++;
    if (busy_cnt !== 6'd3) begin tests_failed++; $display("FAIL flush_pre_cnt: got %0d want 3", busy_cnt); end
    iss_en = 1'b1; iss_rd = 5'd13; wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h4444;
    tick;
    idle;
    rs1 = 5'd4; rs2 = 5'd13;
    #1;
    tests_run++;
    if (busy_cnt !== 6'd3) begin tests_failed++; $display("FAIL setclr_cnt: got %0d want 3", busy_cnt); end
    tests_run++;
    if (rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL setclr_busy4: got %b want 0", rs1_busy); end
    tests_run++;
    if (rs2_busy !== 1'b1) begin tests_failed++; $display("FAIL setclr_busy13: got %b want 1", rs2_busy); end
    flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd20;
    tick;
    idle;
    rs1 = 5'd20;
    #1;
    tests_run++;
    if (busy_cnt !== 6'd0) begin tests_failed++; $display("FAIL flush_cnt: got %0d want 0", busy_cnt); end
    tests_run++;
    if (rs1_busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy20: got %b want 0", rs1_busy); end
    tests_run++;
    if (rs2_busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy13: got %b want 0", rs2_busy); end
    rs1 = 5'd7; rs2 = 5'd9;
    #1;
    tests_run++;
    if (rd1 !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL flush_rd7: got %h want a5a5a5a5", rd1); end
    tests_run++;
    if (rd2 !== 32'h99) begin tests_failed++; $display("FAIL flush_rd9: got %h want 99", rd2); end
    $display("[TB] test_flush done");
  endtask

  task automatic test_no_bypass;
    iss_en = 1'b1; iss_rd = 5'd2;
    tick;
    idle;
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h55; rs2 = 5'd2; rs2_use = 1'b1;
    #1;
    tests_run++;
    if (rd2_nb !== 32'h0) begin tests_failed++; $display("FAIL nb_old_rd2: got %h want 0", rd2_nb); end
    tests_run++;
    if (rs2_busy_nb !== 1'b1) begin tests_failed++; $display("FAIL nb_old_busy: got %b want 1", rs2_busy_nb); end
    tests_run++;
    if (rd2 !== 32'h55) begin tests_failed++; $display("FAIL byp_rd2: got %h want 55", rd2); end
    tests_run++;
    if (rs2_busy !== 1'b0) begin tests_failed++; $display("FAIL byp_busy: got %b want 0", rs2_busy); end
    tick;
    idle;
    #1;
    tests_run++;
    if (rd2_nb !== 32'h55) begin tests_failed++; $display("FAIL nb_new_rd2: got %h want 55", rd2_nb); end
    tests_run++;
    if (rs2_busy_nb !== 1'b0) begin tests_failed++; $display("FAIL nb_new_busy: got %b want 0", rs2_busy_nb); end
    tests_run++;
    if (stall_nb !== 1'b0) begin tests_failed++; $display("FAIL nb_new_stall: got %b want 0", stall_nb); end
    rs2_use = 1'b0;
    $display("[TB] test_no_bypass done");
  endtask

  initial begin
    reset = 1'b1;
    rs1 = '0; rs2 = '0; iss_rd = '0; wb_rd = '0; wb_data = '0;
    rs1_use = 1'b0; rs2_use = 1'b0;
    idle;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset;
    test_zero_reg;
    test_hazard;
    test_iss_wb_same_reg;
    test_flush;
    test_no_bypass;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
